// File: rtl/me_arbiter_if.sv
// Bundle of the two requester ports, the shared engine port and the busy flag.
// slave = arbiter side, master = requesters/engine side.
interface me_arbiter_if #(
  parameter int W = 64
);
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_m, req0_N;
  logic         rsp0_valid, rsp0_ready, rsp0_err;
  logic [W-1:0] rsp0_s;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_m, req1_N;
  logic         rsp1_valid, rsp1_ready, rsp1_err;
  logic [W-1:0] rsp1_s;
  logic [W-1:0] me_a, me_m, me_N, me_s;
  logic         me_rst_n, me_ready_n;
  logic         busy;

  modport slave (
    input  req0_valid, req0_a, req0_m, req0_N, rsp0_ready,
    input  req1_valid, req1_a, req1_m, req1_N, rsp1_ready,
    input  me_s, me_ready_n,
    output req0_ready, rsp0_valid, rsp0_s, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_s, rsp1_err,
    output me_a, me_m, me_N, me_rst_n, busy
  );

  modport master (
    output req0_valid, req0_a, req0_m, req0_N, rsp0_ready,
    output req1_valid, req1_a, req1_m, req1_N, rsp1_ready,
    output me_s, me_ready_n,
    input  req0_ready, rsp0_valid, rsp0_s, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_s, rsp1_err,
    input  me_a, me_m, me_N, me_rst_n, busy
  );
endinterface

// File: rtl/me_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine between two requesters.
// One operation in flight; engine is started by releasing me_rst_n and timed out after TIMEOUT cycles.
module me_arbiter #(
  parameter int W       = 64,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  me_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              req_valid, rsp_ready;
  logic [1:0][W-1:0]       req_a, req_m, req_n;
  logic                    gnt, gnt_nxt, last, err, done, tmo, in_resp;
  logic [TW-1:0]           cnt;
  logic [W-1:0]            result, op_a, op_m, op_n;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a     = {bus.req1_a, bus.req0_a};
  assign req_m     = {bus.req1_m, bus.req0_m};
  assign req_n     = {bus.req1_N, bus.req0_N};

  // Tie goes to the port not served last; a lone requester always wins.
  assign gnt_nxt = (&req_valid) ? ~last : req_valid[1];

  // The engine's done is stale in the first RUN cycle, so it is only trusted from cnt==1 on.
  assign done = (state == RUN) && !bus.me_ready_n && (cnt != '0);
  assign tmo  = (state == RUN) && (cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (done || tmo) state_nxt = RESP;
      RESP:    if (rsp_ready[gnt]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
      op_a   <= '0;
      op_m   <= '0;
      op_n   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|req_valid) begin
          op_a <= req_a[gnt_nxt];
          op_m <= req_m[gnt_nxt];
          op_n <= req_n[gnt_nxt];
          gnt  <= gnt_nxt;
          last <= gnt_nxt;
        end
        LOAD: cnt <= '0;
        RUN: begin
          cnt <= cnt + TW'(1);
          if (done) begin
            result <= bus.me_s;
            err    <= 1'b0;
          end else if (tmo) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_resp        = (state == RESP);
  assign bus.req0_ready = (state == IDLE) && req_valid[0] && !gnt_nxt;
  assign bus.req1_ready = (state == IDLE) && req_valid[1] &&  gnt_nxt;
  assign bus.rsp0_valid = in_resp && !gnt;
  assign bus.rsp1_valid = in_resp &&  gnt;
  assign bus.rsp0_s     = (in_resp && !gnt) ? result : '0;
  assign bus.rsp1_s     = (in_resp &&  gnt) ? result : '0;
  assign bus.rsp0_err   = in_resp && !gnt && err;
  assign bus.rsp1_err   = in_resp &&  gnt && err;
  assign bus.me_a       = op_a;
  assign bus.me_m       = op_m;
  assign bus.me_N       = op_n;
  assign bus.me_rst_n   = (state == RUN);
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_me_arbiter.sv
// Bench for me_arbiter: behavioural engine + transaction model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_me_arbiter;
  localparam int W = 32, TIMEOUT = 16, TW = 8, NEVER = 1000;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  me_arbiter_if #(.W(W)) bus();
  me_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .TW(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [W-1:0] a, m, n; } op_t;
  typedef struct { int port; logic [W-1:0] s; logic err; int lat; } log_t;

  op_t  q0[$], q1[$];
  log_t rlog[$];
  op_t  cur[2];
  logic [1:0] vld = 2'b00, rr = 2'b00, acc_seen = 2'b00;
  int rr_pct = 100, drop_pct = 0, force_lat = -1;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int eng_cnt = 0, eng_lat = NEVER;
  bit eng_stale = 1'b0;

  function automatic logic [W-1:0] modexp(logic [W-1:0] a, logic [W-1:0] m, logic [W-1:0] n);
    logic [2*W-1:0] r, b;
    if (n == 0) return '0;
    r = 1 % n;
    b = a % n;
    for (int i = 0; i < W; i++) begin
      if (m[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r[W-1:0];
  endfunction

  function automatic op_t mk(logic [W-1:0] a, logic [W-1:0] m, logic [W-1:0] n);
    op_t o;
    o.a = a; o.m = m; o.n = n;
    return o;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // requester wiring
  assign bus.req0_valid = vld[0];
  assign bus.req0_a = cur[0].a;
  assign bus.req0_m = cur[0].m;
  assign bus.req0_N = cur[0].n;
  assign bus.req1_valid = vld[1];
  assign bus.req1_a = cur[1].a;
  assign bus.req1_m = cur[1].m;
  assign bus.req1_N = cur[1].n;
  assign bus.rsp0_ready = rr[0];
  assign bus.rsp1_ready = rr[1];

  // engine: done eng_lat cycles after release; optional stale done in the first cycle
  assign bus.me_ready_n = !(bus.me_rst_n && ((eng_cnt >= eng_lat) || (eng_stale && eng_cnt == 0)));
  assign bus.me_s = (eng_stale && eng_cnt == 0) ? 32'hBAD0BAD0 : modexp(bus.me_a, bus.me_m, bus.me_N);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    eng_cnt <= bus.me_rst_n ? eng_cnt + 1 : 0;
  end

  // requester drivers
  always @(posedge clk) begin
    bit dropped;
    #1;
    for (int p = 0; p < 2; p++) begin
      dropped = 1'b0;
      rr[p] = ($urandom_range(0, 99) < rr_pct);
      if (!rst_n) vld[p] = 1'b0;
      else begin
        if (acc_seen[p]) vld[p] = 1'b0;
        else if (vld[p] && $urandom_range(0, 99) < drop_pct) begin
          vld[p] = 1'b0;
          dropped = 1'b1;
        end
        if (!vld[p] && !dropped) begin
          if (p == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); vld[0] = 1'b1; end
          if (p == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); vld[1] = 1'b1; end
        end
      end
    end
  end

  // model: an operation accepted in cycle E shows LOAD at E+1, RUN from E+2, RESP from E+3+idx_end
  bit in_op = 1'b0, last_m = 1'b1, g = 1'b0, exp_err = 1'b0, prev_rsp = 1'b0;
  int E = 0, idx_end = 0, obs_acc = 0, obs_lat = 0, d, lat;
  logic [W-1:0] exp_s, ma = '0, mm = '0, mn = '0;
  logic [1:0] er;
  bit g_n, run, resp, rsp_now;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_op = 1'b0; last_m = 1'b1; ma = '0; mm = '0; mn = '0;
      acc_seen = 2'b00; prev_rsp = 1'b0;
    end else begin
      er  = 2'b00;
      g_n = (vld == 2'b11) ? !last_m : vld[1];
      if (!in_op && vld != 2'b00) er[g_n] = 1'b1;
      d    = cyc - E;
      run  = in_op && d >= 2 && d < 3 + idx_end;
      resp = in_op && d >= 3 + idx_end;
      chk("busy",       W'(bus.busy),       W'(in_op));
      chk("req0_ready", W'(bus.req0_ready), W'(er[0]));
      chk("req1_ready", W'(bus.req1_ready), W'(er[1]));
      chk("me_rst_n",   W'(bus.me_rst_n),   W'(run));
      chk("me_a", bus.me_a, ma);
      chk("me_m", bus.me_m, mm);
      chk("me_N", bus.me_N, mn);
      chk("rsp0_valid", W'(bus.rsp0_valid), W'(resp && !g));
      chk("rsp1_valid", W'(bus.rsp1_valid), W'(resp && g));
      chk("rsp0_s",     bus.rsp0_s, (resp && !g) ? exp_s : '0);
      chk("rsp1_s",     bus.rsp1_s, (resp && g) ? exp_s : '0);
      chk("rsp0_err",   W'(bus.rsp0_err), W'(resp && !g && exp_err));
      chk("rsp1_err",   W'(bus.rsp1_err), W'(resp && g && exp_err));

      // DUT-observed latency from accept cycle to first rsp_valid cycle
      if (bus.req0_ready || bus.req1_ready) obs_acc = cyc;
      rsp_now = bus.rsp0_valid || bus.rsp1_valid;
      if (rsp_now && !prev_rsp) obs_lat = cyc - obs_acc;
      prev_rsp = rsp_now;
      if (bus.rsp0_valid && rr[0]) rlog.push_back('{0, bus.rsp0_s, bus.rsp0_err, obs_lat});
      if (bus.rsp1_valid && rr[1]) rlog.push_back('{1, bus.rsp1_s, bus.rsp1_err, obs_lat});

      acc_seen = er;
      if (er != 2'b00) begin
        in_op = 1'b1; E = cyc; g = g_n; last_m = g_n;
        ma = cur[g_n].a; mm = cur[g_n].m; mn = cur[g_n].n;
        if (force_lat >= 0) lat = force_lat;
        else begin
          case ($urandom_range(0, 9))
            0:       lat = TIMEOUT - 1;
            1:       lat = TIMEOUT;
            2:       lat = NEVER;
            default: lat = $urandom_range(1, TIMEOUT - 2);
          endcase
        end
        eng_lat   = lat;
        eng_stale = ($urandom_range(0, 1) == 1);
        idx_end   = (lat <= TIMEOUT - 1) ? lat : TIMEOUT - 1;
        exp_err   = (lat > TIMEOUT - 1);
        exp_s     = exp_err ? '0 : modexp(ma, mm, mn);
      end else if (resp && rr[g]) in_op = 1'b0;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic wait_log(int n, int budget);
    int t = 0;
    while (rlog.size() < n && t < budget) begin tick(1); t++; end
    chk("wait_log_count", W'(rlog.size()), W'(n));
  endtask

  task automatic chk_log(int idx, int port, logic [W-1:0] s, logic err, int lat);
    if (rlog.size() <= idx) begin
      chk("log_missing", W'(rlog.size()), W'(idx + 1));
      return;
    end
    chk($sformatf("log%0d_port", idx), W'(rlog[idx].port), W'(port));
    chk($sformatf("log%0d_s", idx), rlog[idx].s, s);
    chk($sformatf("log%0d_err", idx), W'(rlog[idx].err), W'(err));
    if (lat >= 0) chk($sformatf("log%0d_lat", idx), W'(rlog[idx].lat), W'(lat));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, nlog;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("pin_modexp_5_3_13", modexp(5, 3, 13), 8);
    chk("pin_modexp_2_10_1000", modexp(2, 10, 1000), 24);

    // 1: single op on port 0, engine done 3 cycles after release -> k=4
    force_lat = 3;
    q0.push_back(mk(5, 3, 13));
    wait_log(1, 100);
    chk_log(0, 0, 8, 1'b0, 6);

    // 2: simultaneous requests after reset, port 0 first
    reset_dut();
    force_lat = 2;
    q0.push_back(mk(5, 3, 13));
    q1.push_back(mk(2, 10, 1000));
    wait_log(3, 200);
    chk_log(1, 0, 8, 1'b0, 5);
    chk_log(2, 1, 24, 1'b0, -1);

    // 3: both continuously valid -> strict alternation
    force_lat = -1;
    q0.push_back(mk(3, 3, 100)); q0.push_back(mk(4, 2, 100));
    q1.push_back(mk(6, 2, 100)); q1.push_back(mk(7, 2, 100));
    wait_log(7, 400);
    for (int i = 3; i < 7; i++)
      if (rlog.size() > i) chk($sformatf("fair_order%0d", i), W'(rlog[i].port), W'((i - 3) % 2));

    // 4: engine never done -> timeout after 2+TIMEOUT cycles
    force_lat = NEVER;
    q0.push_back(mk(7, 2, 11));
    wait_log(8, 200);
    chk_log(7, 0, 0, 1'b1, 2 + TIMEOUT);

    // 5: port 0 response stalled while port 1 waits
    force_lat = 2;
    rr_pct = 0;
    q0.push_back(mk(5, 3, 13));
    tick(2);
    q1.push_back(mk(2, 10, 1000));
    t = 0;
    while (!bus.rsp0_valid && t < 100) begin tick(1); t++; end
    chk("stall_rsp0_seen", W'(bus.rsp0_valid), W'(1));
    tick(5);
    rr_pct = 100;
    wait_log(10, 200);
    chk_log(8, 0, 8, 1'b0, 5);
    chk_log(9, 1, 24, 1'b0, -1);

    // 6: reset in the middle of RUN discards the op; a fresh op then completes
    force_lat = 10;
    q0.push_back(mk(3, 4, 7));
    tick(6);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(20);
    chk("reset_discard_log", W'(rlog.size()), W'(10));
    force_lat = 2;
    q0.push_back(mk(3, 4, 7));
    wait_log(11, 100);
    chk_log(10, 0, 4, 1'b0, 5);

    // randomized traffic, stalls, drops and occasional resets
    force_lat = -1;
    rr_pct    = 70;
    drop_pct  = 5;
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 9) < 3)
        q0.push_back(mk($urandom, $urandom_range(0, 4095),
                        ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 20)) : ($urandom | 32'h1)));
      if (q1.size() < 2 && $urandom_range(0, 9) < 3)
        q1.push_back(mk($urandom, $urandom, W'($urandom_range(1, 100000))));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      tick(1);
    end
    drop_pct = 0;
    rr_pct   = 100;
    nlog     = rlog.size();
    t = 0;
    while ((q0.size() > 0 || q1.size() > 0 || in_op || vld != 2'b00) && t < 500) begin tick(1); t++; end
    chk("drain_idle", W'(bus.busy), W'(0));
    chk("random_ops_done", W'(rlog.size() > nlog || nlog > 20), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
